module_secded_display_seq: RTL

Clocked, parametrised SECDED (extended Hamming) receive-and-display block for the Proyecto1 board flow.
- Captures a received codeword on a valid strobe and classifies it through a 2-stage pipeline as no error, single error or double error.
- Outputs the corrected data word, error flags and saturating error statistics.
- Drives N_DIG time-multiplexed 7-segment digits, with selectable display content.
- Sits directly between the codeword switches/receiver and the board LEDs and displays.

---
 rtl/secded_pkg.sv | 45 ++++
 rtl/module_secded_display_seq_scan.sv | 44 ++++
 rtl/module_secded_display_seq.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/secded_pkg.sv
// rtl/secded_pkg.sv - shared SECDED types, parity sizing and 7-segment glyphs
package secded_pkg;

  // Smallest r with 2^r >= data_w + r + 1
  function automatic int par_bits(input int data_w);
    int r;
    r = 0;
    for (int i = 1; i < 31; i++) begin
      if (r == 0 && (1 << i) >= data_w + i + 1) r = i;
    end
    return r;
  endfunction

  typedef enum logic [1:0] {ERR_NONE, ERR_SINGLE, ERR_DOUBLE} err_kind_t;

  // Segment order {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_D     = 7'h21;

  function automatic logic [6:0] hex7seg(input logic [3:0] nibble);
    logic [6:0] s;
    case (nibble)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/module_secded_display_seq_scan.sv
// rtl/module_secded_display_seq_scan.sv - time-multiplexed digit scanner
module module_display_scan
  import secded_pkg::*;
#(
  parameter int N_DIG       = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_DIG*7-1:0] glyphs,
  output logic [6:0]         seg,
  output logic [N_DIG-1:0]   an
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(N_DIG);

  logic [CW-1:0] scan_cnt;
  logic [IW-1:0] dig_idx;
  logic          disp_en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      dig_idx  <= '0;
      disp_en  <= 1'b0;
    end else begin
      disp_en <= 1'b1;
      if (scan_cnt == CW'(REFRESH_DIV - 1)) begin
        scan_cnt <= '0;
        dig_idx  <= (dig_idx == IW'(N_DIG - 1)) ? '0 : dig_idx + IW'(1);
      end else begin
        scan_cnt <= scan_cnt + CW'(1);
      end
    end
  end

  // Segments stay blank for the cycle following reset
  always_comb begin
    an  = ~(N_DIG'(1) << dig_idx);
    seg = disp_en ? glyphs[dig_idx*7 +: 7] : SEG_BLANK;
  end

endmodule

// File: rtl/module_secded_display_seq.sv
// rtl/module_secded_display_seq.sv - pipelined SECDED receiver with LED and 7-segment output
module module_secded_display_seq
  import secded_pkg::*;
#(
  parameter int DATA_W      = 4,
  parameter int N_DIG       = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = 8,
  localparam int PAR_W      = par_bits(DATA_W),
  localparam int N          = DATA_W + PAR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      palabra_rx,
  input  logic              rx_valid,
  input  logic [1:0]        mode,
  input  logic              clr_stats,
  output logic [6:0]        seg,
  output logic [N_DIG-1:0]  an,
  output logic [DATA_W-1:0] led_out,
  output logic              led_sec,
  output logic              led_ded,
  output logic              dout_valid
);

  localparam int DATA_DIG = (DATA_W + 3) / 4;
  localparam int CNT_DIG  = (CNT_W + 3) / 4;
  localparam int PW       = 4 * N_DIG + CNT_W + DATA_W + PAR_W;

  logic [N-1:0]       s1_cw;
  logic               v1;
  logic [PAR_W-1:0]   syn;
  logic               pg;
  logic [N-1:0]       fixed_cw;
  logic [DATA_W-1:0]  data_fix;
  err_kind_t          kind;
  logic [PAR_W-1:0]   pos;

  logic [PAR_W-1:0]   err_pos;
  err_kind_t          err_kind;
  logic [CNT_W-1:0]   sec_cnt;
  logic [CNT_W-1:0]   ded_cnt;

  logic [PW-1:0]      data_pad;
  logic [PW-1:0]      sec_pad;
  logic [PW-1:0]      ded_pad;
  logic [PW-1:0]      pos_pad;
  logic [N_DIG*7-1:0] glyphs;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_cw <= '0;
      v1    <= 1'b0;
    end else begin
      v1 <= rx_valid;
      if (rx_valid) s1_cw <= palabra_rx;
    end
  end

  always_comb begin
    int j;
    syn = '0;
    pg  = ^s1_cw;
    for (int p = 1; p < N; p++) begin
      if (s1_cw[p]) syn = syn ^ p[PAR_W-1:0];
    end
    fixed_cw = s1_cw;
    kind     = ERR_NONE;
    pos      = '0;
    if (syn == '0) begin
      if (pg) kind = ERR_SINGLE;
    end else if (pg && int'(syn) <= N - 1) begin
      kind           = ERR_SINGLE;
      pos            = syn;
      fixed_cw[syn]  = ~s1_cw[syn];
    end else begin
      kind = ERR_DOUBLE;
    end
    // Data bits fill the non-power-of-two positions, LSB first
    j        = 0;
    data_fix = '0;
    for (int p = 1; p < N; p++) begin
      if ((p & (p - 1)) != 0) begin
        data_fix[j] = fixed_cw[p];
        j++;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_out    <= '0;
      led_sec    <= 1'b0;
      led_ded    <= 1'b0;
      err_pos    <= '0;
      err_kind   <= ERR_NONE;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= v1;
      if (v1) begin
        led_out  <= data_fix;
        led_sec  <= (kind == ERR_SINGLE);
        led_ded  <= (kind == ERR_DOUBLE);
        err_pos  <= pos;
        err_kind <= kind;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr_stats) begin
      sec_cnt <= '0;
      ded_cnt <= '0;
    end else if (v1) begin
      if (kind == ERR_SINGLE && sec_cnt != '1) sec_cnt <= sec_cnt + CNT_W'(1);
      if (kind == ERR_DOUBLE && ded_cnt != '1) ded_cnt <= ded_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    data_pad = '0;
    sec_pad  = '0;
    ded_pad  = '0;
    pos_pad  = '0;
    data_pad[DATA_W-1:0] = led_out;
    sec_pad[CNT_W-1:0]   = sec_cnt;
    ded_pad[CNT_W-1:0]   = ded_cnt;
    pos_pad[PAR_W-1:0]   = err_pos;
    glyphs = {N_DIG{SEG_BLANK}};
    for (int k = 0; k < N_DIG; k++) begin
      case (mode)
        2'd0: if (k < DATA_DIG) glyphs[k*7 +: 7] = hex7seg(data_pad[k*4 +: 4]);
        2'd1: begin
          if (k == 0) begin
            glyphs[k*7 +: 7] = hex7seg(pos_pad[3:0]);
          end else if (k == 1) begin
            case (err_kind)
              ERR_NONE:   glyphs[k*7 +: 7] = SEG_DASH;
              ERR_SINGLE: glyphs[k*7 +: 7] = SEG_E;
              default:    glyphs[k*7 +: 7] = SEG_D;
            endcase
          end
        end
        2'd2: if (k < CNT_DIG) glyphs[k*7 +: 7] = hex7seg(sec_pad[k*4 +: 4]);
        default: if (k < CNT_DIG) glyphs[k*7 +: 7] = hex7seg(ded_pad[k*4 +: 4]);
      endcase
    end
  end

  module_display_scan #(
    .N_DIG      (N_DIG),
    .REFRESH_DIV(REFRESH_DIV)
  ) u_scan (
    .clk   (clk),
    .rst_n (rst_n),
    .glyphs(glyphs),
    .seg   (seg),
    .an    (an)
  );

endmodule
